// File: rtl/spi_crypto_master.sv
// SPI master for the AES cipher slaves: shifts a data block and a key out, idles for a
// programmable gap, then shifts the result block back in from the selected slave.
//
// state | meaning
// IDLE  | waiting for start; invalid sel pulses err
// SETUP | chip select asserted, first bit presented on mosi, sclk low
// TX    | shifting {data,key} out, MSB first
// GAP   | dummy bits with mosi low while the slave computes
// RX    | shifting the result in from miso[sel]
// DONE  | one-cycle completion; data_out updated, chip select released
module spi_crypto_master #(
  parameter int DATA_W     = 128,
  parameter int KEY_W      = 128,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = 1,
  parameter int CLK_DIV    = 2,
  parameter int GAP_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [KEY_W-1:0]      key_in,
  input  logic [NUM_SLAVES-1:0] miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [NUM_SLAVES-1:0] cs_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     data_out
);

  localparam int TX_W     = DATA_W + KEY_W;
  localparam int MAX_BITS = (GAP_BITS > TX_W) ? GAP_BITS : TX_W;
  localparam int BIT_CW   = $clog2(MAX_BITS + 1);
  localparam int DIV_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_CW-1:0] DIV_LOAD = DIV_CW'(CLK_DIV - 1);
  localparam logic [BIT_CW-1:0] TX_LOAD  = BIT_CW'(TX_W - 1);
  localparam logic [BIT_CW-1:0] GAP_LOAD = BIT_CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [BIT_CW-1:0] RX_LOAD  = BIT_CW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_TX    = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_RX    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic [SEL_W-1:0]  sel_q;
  logic [TX_W-1:0]   tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DIV_CW-1:0] div_cnt;
  logic [BIT_CW-1:0] bit_cnt;
  logic              sel_ok;
  logic              miso_bit;

  assign sel_ok = ({1'b0, sel} < (SEL_W + 1)'(NUM_SLAVES));
  assign busy   = (state == S_SETUP) || (state == S_TX) || (state == S_GAP) || (state == S_RX);
  assign done   = (state == S_DONE);
  // Shifting in zeros leaves tx_sh clear once TX is over; the state gate keeps mosi low regardless.
  assign mosi   = ((state == S_SETUP) || (state == S_TX)) && tx_sh[TX_W-1];

  always_comb begin
    cs_n     = '1;
    miso_bit = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        miso_bit = miso[i];
        if (busy) cs_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sel_q    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sclk     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (sel_ok) begin
              tx_sh   <= {data_in, key_in};
              sel_q   <= sel;
              rx_sh   <= '0;
              div_cnt <= DIV_LOAD;
              state   <= S_SETUP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (div_cnt == '0) begin
            state   <= S_TX;
            sclk    <= 1'b1;
            div_cnt <= DIV_LOAD;
            bit_cnt <= TX_LOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_TX, S_GAP, S_RX: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (sclk) begin
              // Falling edge: present the next bit and capture the slave's current bit.
              sclk  <= 1'b0;
              tx_sh <= tx_sh << 1;
              if (state == S_RX) rx_sh <= (rx_sh << 1) | DATA_W'(miso_bit);
            end else if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              sclk    <= 1'b1;
            end else begin
              case (state)
                S_TX: begin
                  sclk <= 1'b1;
                  if (GAP_BITS > 0) begin
                    state   <= S_GAP;
                    bit_cnt <= GAP_LOAD;
                  end else begin
                    state   <= S_RX;
                    bit_cnt <= RX_LOAD;
                  end
                end
                S_GAP: begin
                  sclk    <= 1'b1;
                  state   <= S_RX;
                  bit_cnt <= RX_LOAD;
                end
                default: begin
                  state    <= S_DONE;
                  data_out <= rx_sh;
                end
              endcase
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_crypto_master.sv
// Bench for spi_crypto_master: an XOR-echo slave model on instance a (CLK_DIV=1, SEL_W=2)
// and a timing-focused instance b (CLK_DIV=3) for back-to-back frames.
module tb_spi_crypto_master;

  localparam int DW  = 8;
  localparam int KW  = 8;
  localparam int GB  = 2;
  localparam int NB  = DW + KW + GB + DW;
  localparam int CDA = 1;
  localparam int CDB = 3;

  logic clk, rst;
  int checks = 0;
  int errors = 0;

  logic          start_a, sclk_a, mosi_a, busy_a, done_a, err_a;
  logic [1:0]    sel_a, miso_a, cs_n_a;
  logic [DW-1:0] data_a, data_out_a;
  logic [KW-1:0] key_a;

  logic          start_b, sclk_b, mosi_b, busy_b, done_b, err_b;
  logic [0:0]    sel_b;
  logic [1:0]    miso_b, cs_n_b;
  logic [DW-1:0] data_b, data_out_b;
  logic [KW-1:0] key_b;

  spi_crypto_master #(.DATA_W(DW), .KEY_W(KW), .NUM_SLAVES(2), .SEL_W(2),
                      .CLK_DIV(CDA), .GAP_BITS(GB)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sel(sel_a), .data_in(data_a), .key_in(key_a),
    .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a),
    .done(done_a), .err(err_a), .data_out(data_out_a));

  spi_crypto_master #(.DATA_W(DW), .KEY_W(KW), .NUM_SLAVES(2), .SEL_W(1),
                      .CLK_DIV(CDB), .GAP_BITS(GB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sel(sel_b), .data_in(data_b), .key_in(key_b),
    .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b),
    .done(done_b), .err(err_b), .data_out(data_out_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave b always answers ones on line 0 and zeros on line 1.
  assign miso_b = 2'b01;

  // Behavioural slaves on instance a: capture data+key, note gap bits, echo data^key.
  logic [DW+KW-1:0] cap [2];
  logic [GB-1:0]    gapv [2];
  int               nrise [2];

  always @(posedge sclk_a or posedge cs_n_a[0] or posedge cs_n_a[1] or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_n_a[g] !== 1'b0) begin
        nrise[g]  = 0;
        miso_a[g] = 1'($urandom);
      end else if (sclk_a === 1'b1) begin
        if (nrise[g] < DW + KW) begin
          cap[g] = {cap[g][DW+KW-2:0], mosi_a};
        end else if (nrise[g] < DW + KW + GB) begin
          gapv[g] = {gapv[g][GB-2:0], mosi_a};
        end else if (nrise[g] < NB) begin
          logic [DW-1:0] res;
          res = cap[g][DW+KW-1:KW] ^ cap[g][KW-1:0];
          miso_a[g] = res[DW-1-(nrise[g]-DW-KW-GB)];
        end
        nrise[g] = nrise[g] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: plain frame; 1: extra start at cycle 20; 2: reset at cycle 30
  task automatic run_txn(input logic [DW-1:0] d, input logic [KW-1:0] k,
                         input logic [1:0] s, input int mode);
    int tdone;
    int ndone;
    logic [DW-1:0] prev_out;
    logic [1:0] cs_exp;
    tdone    = 1 + CDA + NB * 2 * CDA;
    ndone    = 0;
    cs_exp   = ~(2'b01 << s);
    @(negedge clk);
    prev_out = data_out_a;
    start_a = 1'b1; sel_a = s; data_a = d; key_a = k;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    if (s >= 2) begin
      chk("err_pulse", 32'(err_a), 32'd1);
      chk("err_cs", 32'(cs_n_a), 32'h3);
      chk("err_busy", 32'(busy_a), 32'd0);
      for (int n = 2; n < 7; n++) begin
        @(negedge clk);
        chk("err_clear", 32'(err_a), 32'd0);
        chk("err_sclk", 32'(sclk_a), 32'd0);
        chk("err_cs_hold", 32'(cs_n_a), 32'h3);
      end
      chk("err_dout", 32'(data_out_a), 32'(prev_out));
      return;
    end
    for (int n = 1; n <= tdone + 1; n++) begin
      if (n > 1) @(negedge clk);
      if (mode == 2 && n == 30) begin
        rst = 1'b1;
        #1;
        chk("rst_cs", 32'(cs_n_a), 32'h3);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_dout", 32'(data_out_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      chk("busy", 32'(busy_a), 32'(n < tdone));
      chk("done", 32'(done_a), 32'(n == tdone));
      chk("cs_n", 32'(cs_n_a), (n < tdone) ? 32'(cs_exp) : 32'h3);
      chk("err_idle", 32'(err_a), 32'd0);
      if (done_a) ndone++;
      if (mode == 1 && n == 20) begin
        start_a = 1'b1; sel_a = 2'd1; data_a = 8'h11; key_a = 8'h22;
      end
      if (mode == 1 && n == 21) start_a = 1'b0;
    end
    chk("mosi_bits", 32'(cap[s]), 32'({d, k}));
    chk("gap_bits", 32'(gapv[s]), 32'd0);
    chk("data_out", 32'(data_out_a), 32'(d ^ k));
    chk("ndone", ndone, 1);
  endtask

  task automatic frame_b(input logic s, input logic [DW-1:0] exp_out);
    int n, nr, r0, r1;
    logic ps;
    start_b = 1'b1; sel_b = s; data_b = 8'($urandom); key_b = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    n = 1; nr = 0; r0 = 0; r1 = 0; ps = 1'b0;
    while (!done_b && n < 400) begin
      if (sclk_b && !ps) begin
        if (nr == 0) r0 = n;
        else if (nr == 1) r1 = n;
        nr++;
      end
      if (n == 2) chk("b_cs", 32'(cs_n_b), s ? 32'h1 : 32'h2);
      ps = sclk_b;
      @(negedge clk);
      n++;
    end
    chk("b_latency", n, 1 + CDB + NB * 2 * CDB);
    chk("b_period", r1 - r0, 2 * CDB);
    chk("b_rises", nr, NB);
    chk("b_dout", 32'(data_out_b), 32'(exp_out));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; sel_a = '0; data_a = '0; key_a = '0;
    start_b = 1'b0; sel_b = '0; data_b = '0; key_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk0", 32'(sclk_a), 32'd0);
    chk("rst_mosi0", 32'(mosi_a), 32'd0);
    chk("rst_cs0", 32'(cs_n_a), 32'h3);
    chk("rst_busy0", 32'(busy_a), 32'd0);
    chk("rst_done0", 32'(done_a), 32'd0);
    chk("rst_err0", 32'(err_a), 32'd0);
    chk("rst_dout0", 32'(data_out_a), 32'd0);
    rst = 1'b0;

    run_txn(8'hA5, 8'h3C, 2'd0, 0);
    run_txn(8'hA5, 8'h3C, 2'd1, 0);
    run_txn(8'hA5, 8'h3C, 2'd2, 0);
    run_txn(8'hA5, 8'h3C, 2'd0, 1);
    run_txn(8'hA5, 8'h3C, 2'd1, 2);
    run_txn(8'hA5, 8'h3C, 2'd0, 0);
    for (int i = 0; i < 10; i++)
      run_txn(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 0);

    @(negedge clk);
    frame_b(1'b0, 8'hFF);
    @(negedge clk);
    chk("b_cs_gap", 32'(cs_n_b), 32'h3);
    frame_b(1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
